// File: rtl/axi4_stream_pkt_trunc_pkg.sv
// Shared definitions for the AXI4-Stream packet truncator and its helpers:
// the FSM state type plus the byte-counting and keep-masking functions.
package axi4_stream_pkg;

    // Widest tkeep the helper functions accept (1024-bit tdata).
    localparam int MAX_KEEP_W = 128;

    typedef enum logic [0:0] {
        PASS_S  = 1'b0,
        DRAIN_S = 1'b1
    } trunc_state_e;

    // Number of set bits in a byte-enable vector.
    function automatic logic [7:0] popcount(input logic [MAX_KEEP_W-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    // Byte-enable mask with the low n lanes set.
    function automatic logic [MAX_KEEP_W-1:0] mask_low(input int unsigned n);
        logic [MAX_KEEP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_stream_pkt_trunc_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_pkt_trunc_byte_cnt.sv
// Counts the valid bytes of one beat (tkeep | tstrb). Shared with the fragmenter.
module axi4_stream_byte_cnt
    import axi4_stream_pkg::*;
#(
    parameter int KEEP_WIDTH     = 4,
    parameter int BYTE_CNT_WIDTH = $clog2(KEEP_WIDTH)
) (
    input  logic [KEEP_WIDTH-1:0]   tkeep,
    input  logic [KEEP_WIDTH-1:0]   tstrb,
    output logic [BYTE_CNT_WIDTH:0] byte_cnt
);

    logic [MAX_KEEP_W-1:0] lanes;

    // Zero-extend the lane enables to the helper width and count them.
    always_comb begin
        lanes                 = '0;
        lanes[KEEP_WIDTH-1:0] = tkeep | tstrb;
        byte_cnt              = (BYTE_CNT_WIDTH+1)'(popcount(lanes));
    end

endmodule

// File: rtl/axi4_stream_pkt_trunc.sv
// AXI4-Stream packet truncator: caps each packet at max_pkt_size_i bytes,
// closes oversize packets with a masked tlast beat and drops the remainder.
// One registered output stage, full throughput.
// Optional feature: define AXI4_STREAM_PKT_TRUNC_CNT_EN to add trunc_cnt_o,
// a saturating count of truncated packets.
module axi4_stream_pkt_trunc
    import axi4_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH     = 1,
    parameter int MAX_PKT_SIZE_B = 2048,
    parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [PKT_SIZE_WIDTH:0] max_pkt_size_i,
    axi4_stream_if.slave            pkt_i,
    axi4_stream_if.master           pkt_o,
    output logic                    trunc_o
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
    ,
    output logic [31:0]             trunc_cnt_o
`endif
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int BCW    = $clog2(KEEP_W);
    localparam int CW     = PKT_SIZE_WIDTH + 1;

    trunc_state_e state, state_next;

    logic [CW-1:0]         byte_cnt;
    logic [CW-1:0]         byte_cnt_next;
    logic [CW-1:0]         limit_reg;
    logic [CW-1:0]         limit;
    logic [CW-1:0]         sum;
    logic [CW-1:0]         room;
    logic                  first_beat;
    logic [BCW:0]          rx_bytes;
    logic                  in_ready;
    logic                  accept;
    logic                  pass_write;
    logic                  over;
    logic                  cut;
    logic [KEEP_W-1:0]     keep_mask;
    logic [KEEP_W-1:0]     out_keep;
    logic [KEEP_W-1:0]     out_strb;
    logic                  out_last;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DEST_WIDTH-1:0] out_dest;
    logic [USER_WIDTH-1:0] out_user;

    axi4_stream_byte_cnt #(
        .KEEP_WIDTH    (KEEP_W),
        .BYTE_CNT_WIDTH(BCW)
    ) u_byte_cnt (
        .tkeep   (pkt_i.tkeep),
        .tstrb   (pkt_i.tstrb),
        .byte_cnt(rx_bytes)
    );

    assign pkt_i.tready = in_ready;
    assign accept       = pkt_i.tvalid && in_ready;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= PASS_S;
        else          state <= state_next;
    end

    // Next state: enter DRAIN_S on a mid-packet cut, leave it on the dropped tlast.
    always_comb begin
        state_next = state;
        case (state)
            PASS_S:  if (accept && over && !pkt_i.tlast) state_next = DRAIN_S;
            DRAIN_S: if (accept && pkt_i.tlast)          state_next = PASS_S;
            default: state_next = PASS_S;
        endcase
    end

    // Beat shaping: the limit in force is the live input on a first beat and
    // the latched copy afterwards; crossing it masks the keep lanes down to the
    // bytes still allowed and forces tlast.
    always_comb begin
        in_ready      = (state == DRAIN_S) ? 1'b1 : (!pkt_o.tvalid || pkt_o.tready);
        pass_write    = accept && (state == PASS_S);
        limit         = first_beat ? max_pkt_size_i : limit_reg;
        sum           = byte_cnt + CW'(rx_bytes);
        over          = (limit != '0) && (sum >= limit);
        room          = limit - byte_cnt;
        keep_mask     = over ? KEEP_W'(mask_low(32'(room))) : '1;
        out_keep      = pkt_i.tkeep & keep_mask;
        out_strb      = pkt_i.tstrb & keep_mask;
        out_last      = pkt_i.tlast || over;
        cut           = over && (!pkt_i.tlast || (sum > limit));
        byte_cnt_next = (pkt_i.tlast || over) ? '0 : sum;
        out_id        = pkt_i.tid;
        out_dest      = pkt_i.tdest;
        out_user      = pkt_i.tuser;
    end

    // Packet bookkeeping: latch the limit on the first beat, track bytes
    // forwarded so far, and re-arm the first-beat flag after every tlast.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byte_cnt   <= '0;
            limit_reg  <= '0;
            first_beat <= 1'b1;
        end else if (accept) begin
            if (first_beat) limit_reg <= max_pkt_size_i;
            first_beat <= pkt_i.tlast;
            if (state == PASS_S) byte_cnt <= byte_cnt_next;
        end
    end

    // Output register: load on a forwarded beat, otherwise empty once taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_o.tvalid <= 1'b0;
            pkt_o.tdata  <= '0;
            pkt_o.tkeep  <= '0;
            pkt_o.tstrb  <= '0;
            pkt_o.tlast  <= 1'b0;
            pkt_o.tid    <= '0;
            pkt_o.tdest  <= '0;
            pkt_o.tuser  <= '0;
            trunc_o      <= 1'b0;
        end else begin
            trunc_o <= pass_write && cut;
            if (pass_write) begin
                pkt_o.tvalid <= 1'b1;
                pkt_o.tdata  <= pkt_i.tdata;
                pkt_o.tkeep  <= out_keep;
                pkt_o.tstrb  <= out_strb;
                pkt_o.tlast  <= out_last;
                pkt_o.tid    <= out_id;
                pkt_o.tdest  <= out_dest;
                pkt_o.tuser  <= out_user;
            end else if (pkt_o.tready) begin
                pkt_o.tvalid <= 1'b0;
            end
        end
    end

`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
    // Saturating truncation counter, stepping together with the trunc_o pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                                trunc_cnt_o <= '0;
        else if (pass_write && cut && (trunc_cnt_o != '1)) trunc_cnt_o <= trunc_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_trunc.sv
// Self-checking bench for axi4_stream_pkt_trunc (DATA_WIDTH=32).
// Table-driven packet vectors, hand-written corner sequences and randomized
// packets compared against a byte-budget reference model.
module tb_axi4_stream_pkt_trunc;

    localparam int DW  = 32;
    localparam int PSW = 11;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [2:0]  side;
    } beat_t;

    typedef struct {
        int         limit;
        int         nbytes;
        int         exp_beats;
        logic [3:0] exp_last_keep;
        int         exp_trunc;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [PSW:0]   max_size;
    logic           trunc;
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
    logic [31:0]    trunc_cnt;
`endif

    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) in_if ();
    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

    axi4_stream_pkt_trunc #(
        .DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1),
        .MAX_PKT_SIZE_B(2048), .PKT_SIZE_WIDTH(PSW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .max_pkt_size_i(max_size),
        .pkt_i         (in_if),
        .pkt_o         (out_if),
        .trunc_o       (trunc)
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
        ,
        .trunc_cnt_o   (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    failed = 0;
    beat_t exp_q[$];
    int    beats_seen = 0;
    int    trunc_seen = 0;
    logic [3:0] last_keep_seen = '0;
    int    exp_trunc = 0;
    int    cnt_model = 0;
    bit    rand_ready = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] lowMask(input int n);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    // Output monitor: every accepted output beat must be the next one the model predicted.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n === 1'b1) begin
            if (trunc === 1'b1) trunc_seen++;
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
                beats_seen++;
                last_keep_seen = out_if.tkeep;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdata", out_if.tdata, e.data);
                    checkOutput("tkeep", out_if.tkeep, e.keep);
                    checkOutput("tstrb", out_if.tstrb, e.keep);
                    checkOutput("tlast", out_if.tlast, e.last);
                    checkOutput("sideband", {out_if.tid, out_if.tdest, out_if.tuser}, e.side);
                end
            end
        end
    end

    // Downstream ready: always 1, or a coin toss each cycle when enabled.
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Build a packet of nbytes: full beats with a partial tail, or random 1..4-byte beats.
    task automatic makePacket(input int nbytes, input bit random_split, output beat_t beats[$]);
        int left;
        int k;
        beat_t b;
        beats = {};
        left = nbytes;
        while (left > 0) begin
            k = random_split ? int'($urandom_range(1, 4)) : 4;
            if (k > left) k = left;
            left -= k;
            b.data = $urandom;
            b.keep = lowMask(k);
            b.last = (left == 0);
            b.side = 3'($urandom_range(0, 7));
            beats.push_back(b);
        end
    endtask

    // Reference model: the output is the first min(total, limit) bytes of the
    // packet, beat boundaries kept, closed by tlast; truncated when bytes were lost
    // or the packet continued past the budget.
    task automatic expectPacket(input int limit, input beat_t beats[$]);
        int budget;
        int sent;
        int k;
        int o;
        beat_t e;
        budget = (limit == 0) ? 32'h4000_0000 : limit;
        sent = 0;
        foreach (beats[i]) begin
            k = $countones(beats[i].keep);
            o = (k < budget - sent) ? k : budget - sent;
            sent += o;
            e = beats[i];
            e.keep = lowMask(o);
            e.last = beats[i].last || (sent == budget);
            exp_q.push_back(e);
            if (sent == budget && (!beats[i].last || k > o)) begin
                exp_trunc++;
                cnt_model++;
            end
            if (e.last) break;
        end
    endtask

    // Drive one beat starting just after a rising edge; returns just after the accepting edge.
    task automatic sendBeat(input beat_t b);
        int waited;
        bit accepted;
        in_if.tvalid = 1'b1;
        in_if.tdata  = b.data;
        in_if.tkeep  = b.keep;
        in_if.tstrb  = b.keep;
        in_if.tlast  = b.last;
        {in_if.tid, in_if.tdest, in_if.tuser} = b.side;
        waited = 0;
        accepted = 0;
        while (!accepted && waited < 500) begin
            @(negedge clk);
            accepted = (in_if.tready === 1'b1);
            waited++;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic sendPacket(input int limit, input beat_t beats[$], input bit gaps, input bit change_limit);
        max_size = 12'(limit);
        foreach (beats[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            sendBeat(beats[i]);
            if (i == 0 && change_limit) max_size = 12'($urandom_range(0, 2048));
        end
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 2000) begin
            @(posedge clk);
            cnt++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // One table vector: a plain packet, then beat count, last keep and pulse count.
    task automatic applyStimulus(input vec_t v);
        int b0;
        int t0;
        beat_t pkt[$];
        b0 = beats_seen;
        t0 = trunc_seen;
        makePacket(v.nbytes, 1'b0, pkt);
        expectPacket(v.limit, pkt);
        sendPacket(v.limit, pkt, 1'b0, 1'b0);
        waitDrain();
        checkOutput("vec_beats", 64'(beats_seen - b0), 64'(v.exp_beats));
        checkOutput("vec_last_keep", last_keep_seen, v.exp_last_keep);
        checkOutput("vec_trunc", 64'(trunc_seen - t0), 64'(v.exp_trunc));
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
        checkOutput("vec_trunc_cnt", trunc_cnt, 64'(cnt_model));
`endif
    endtask

    initial begin : main
        vec_t  vecs[10];
        beat_t pkt[$];
        beat_t b;
        int    b0;
        int    t0;

        vecs[0] = '{16,   12,  3, 4'hF, 0};
        vecs[1] = '{10,   16,  3, 4'h3, 1};
        vecs[2] = '{8,     8,  2, 4'hF, 0};
        vecs[3] = '{8,     6,  2, 4'h3, 0};
        vecs[4] = '{0,    64, 16, 4'hF, 0};
        vecs[5] = '{6,    20,  2, 4'h3, 1};
        vecs[6] = '{5,     5,  2, 4'h1, 0};
        vecs[7] = '{4,     8,  1, 4'hF, 1};
        vecs[8] = '{3,     2,  1, 4'h3, 0};
        vecs[9] = '{2048, 40, 10, 4'hF, 0};

        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tstrb  = '0;
        in_if.tlast  = 1'b0;
        in_if.tid    = '0;
        in_if.tdest  = '0;
        in_if.tuser  = '0;
        max_size     = '0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", out_if.tvalid, 64'd0);
        checkOutput("reset_tdata", out_if.tdata, 64'd0);
        checkOutput("reset_tkeep", {out_if.tkeep, out_if.tstrb}, 64'd0);
        checkOutput("reset_tlast", out_if.tlast, 64'd0);
        checkOutput("reset_side", {out_if.tid, out_if.tdest, out_if.tuser}, 64'd0);
        checkOutput("reset_trunc", trunc, 64'd0);
        checkOutput("reset_tready", in_if.tready, 64'd1);
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
        checkOutput("reset_trunc_cnt", trunc_cnt, 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // limit=6, 20-byte packet under random backpressure, then an intact packet.
        rand_ready = 1;
        b0 = beats_seen;
        t0 = trunc_seen;
        makePacket(20, 1'b0, pkt);
        expectPacket(6, pkt);
        sendPacket(6, pkt, 1'b0, 1'b0);
        waitDrain();
        checkOutput("bp_beats", 64'(beats_seen - b0), 64'd2);
        checkOutput("bp_last_keep", last_keep_seen, 64'h3);
        checkOutput("bp_trunc", 64'(trunc_seen - t0), 64'd1);
        b0 = beats_seen;
        makePacket(10, 1'b0, pkt);
        expectPacket(6, pkt);
        sendPacket(6, pkt, 1'b0, 1'b0);
        waitDrain();
        checkOutput("bp_next_beats", 64'(beats_seen - b0), 64'd2);
        checkOutput("bp_next_last_keep", last_keep_seen, 64'h3);

        // Random packets, random limits changed after the first beat, gaps and backpressure.
        t0 = trunc_seen;
        exp_trunc = 0;
        for (int n = 0; n < 40; n++) begin
            int lim;
            lim = (n % 5 == 0) ? 0 : int'($urandom_range(1, 24));
            makePacket(int'($urandom_range(1, 40)), 1'b1, pkt);
            expectPacket(lim, pkt);
            sendPacket(lim, pkt, 1'b1, 1'b1);
            waitDrain();
        end
        checkOutput("rand_trunc_total", 64'(trunc_seen - t0), 64'(exp_trunc));
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
        checkOutput("rand_trunc_cnt", trunc_cnt, 64'(cnt_model));
`endif
        rand_ready = 0;
        @(posedge clk);
        #1;

        // limit=4: reset after a 2-byte non-last beat; the next packet starts fresh.
        max_size = 12'd4;
        b.data = 32'hA5A5_0001;
        b.keep = 4'h3;
        b.last = 1'b0;
        b.side = 3'b101;
        sendBeat(b);
        checkOutput("pre_reset_tvalid", out_if.tvalid, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_tvalid", out_if.tvalid, 64'd0);
        checkOutput("mid_reset_tkeep", out_if.tkeep, 64'd0);
        checkOutput("mid_reset_tdata", out_if.tdata, 64'd0);
        cnt_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b0 = beats_seen;
        t0 = trunc_seen;
        makePacket(8, 1'b0, pkt);
        expectPacket(4, pkt);
        sendPacket(4, pkt, 1'b0, 1'b0);
        waitDrain();
        checkOutput("post_reset_beats", 64'(beats_seen - b0), 64'd1);
        checkOutput("post_reset_last_keep", last_keep_seen, 64'hF);
        checkOutput("post_reset_trunc", 64'(trunc_seen - t0), 64'd1);
`ifdef AXI4_STREAM_PKT_TRUNC_CNT_EN
        checkOutput("post_reset_trunc_cnt", trunc_cnt, 64'(cnt_model));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
